// File: rtl/regfile_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_read_arbiter_if
// Request/response bundle between the register-file read arbiter and its
// requesters/consumer.
//   req_valid  per-requester read request
//   req_addr   per-requester register index, requester i in [i*ADDR_W +: ADDR_W]
//   req_ready  one-hot grant (combinational)
//   rsp_valid  response valid
//   rsp_id     requester ID of the response
//   rsp_data   read data
//   rsp_stall  consumer back-pressure, freezes the whole pipeline
// Modports: master = requesters/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_stall;

  modport master (
    output req_valid, req_addr, rsp_stall,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_stall,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_read_arbiter
// Round-robin arbiter sharing one 32-entry register-file read port among
// NUM_REQ requesters. The winning index is registered onto rf_sel_o, the
// read-mux output is captured one cycle later and returned with the
// requester ID. Fixed 2-cycle request-to-response latency, one grant per
// cycle, whole pipeline frozen while rsp_stall is high.
//
// Ports:
//   clk_i       system clock, rising edge
//   reset_n_i   synchronous active-low reset
//   bus         regfile_read_arbiter_if.slave (request/response bundle)
//   rf_sel_o    registered selector to the read-mux S input
//   rf_data_i   read-mux output (combinational from rf_sel_o)
//   busy_o      stage 1 or stage 2 holds a transaction
//
// Optional build macro RF_ARB_PRIORITY_EN: requester 0 gets fixed priority,
// every other requester has a saturating 3-bit wait counter and overrides
// requester 0 once its counter reaches 7 (lowest such index wins).
// ---------------------------------------------------------------------------
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  regfile_read_arbiter_if.slave    bus,
  output logic [ADDR_W-1:0]        rf_sel_o,
  input  logic [DATA_W-1:0]        rf_data_i,
  output logic                     busy_o
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               s1_v_q, s1_v_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [ADDR_W-1:0]  rf_sel_q, rf_sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] cand_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               rr_found_s;
  logic [ID_W-1:0]    rr_idx_s;
  logic               grant_s;
  logic               rr_grant_s;
  logic [ID_W-1:0]    win_idx_s;

  // Pointer advance with wrap at NUM_REQ (NUM_REQ need not be a power of 2).
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] w);
    logic [ID_W-1:0] r;
    if (int'(w) == NUM_REQ - 1) begin
      r = {ID_W{1'b0}};
    end else begin
      r = w + {{(ID_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // No candidates while stalled or in reset, so req_ready stays all-zero.
  assign cand_s = bus.req_valid & {NUM_REQ{~bus.rsp_stall & reset_n_i}};

  // Round-robin search upward from the pointer, wrapping to 0.
  always_comb begin
    logic [ID_W-1:0] idx_v;
    rr_found_s = 1'b0;
    rr_idx_s   = {ID_W{1'b0}};
    idx_v      = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!rr_found_s && cand_s[idx_v]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = idx_v;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

`ifdef RF_ARB_PRIORITY_EN
  logic [2:0]      wait_cnt_q [NUM_REQ];
  logic [2:0]      wait_cnt_d [NUM_REQ];
  logic            starve_found_s;
  logic [ID_W-1:0] starve_idx_s;

  // Lowest-index starved requester (counter saturated) that is requesting.
  always_comb begin
    starve_found_s = 1'b0;
    starve_idx_s   = {ID_W{1'b0}};
    for (int k = 1; k < NUM_REQ; k++) begin
      if (!starve_found_s && cand_s[ID_W'(k)] && (wait_cnt_q[k] == 3'd7)) begin
        starve_found_s = 1'b1;
        starve_idx_s   = ID_W'(k);
      end else begin
        starve_found_s = starve_found_s;
      end
    end
  end

  // Winner: starved requester, then requester 0, then round-robin.
  // Only round-robin grants move the pointer.
  always_comb begin
    grant_s    = 1'b0;
    rr_grant_s = 1'b0;
    win_idx_s  = {ID_W{1'b0}};
    if (starve_found_s) begin
      grant_s   = 1'b1;
      win_idx_s = starve_idx_s;
    end else if (cand_s[0]) begin
      grant_s   = 1'b1;
      win_idx_s = {ID_W{1'b0}};
    end else if (rr_found_s) begin
      grant_s    = 1'b1;
      rr_grant_s = 1'b1;
      win_idx_s  = rr_idx_s;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Wait counters: count stalled-out cycles, clear on grant or request drop.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      wait_cnt_d[k] = wait_cnt_q[k];
      if (k == 0) begin
        wait_cnt_d[k] = 3'd0;
      end else if (!bus.req_valid[ID_W'(k)] || req_ready_s[ID_W'(k)]) begin
        wait_cnt_d[k] = 3'd0;
      end else if (!bus.rsp_stall && (wait_cnt_q[k] != 3'd7)) begin
        wait_cnt_d[k] = wait_cnt_q[k] + 3'd1;
      end else begin
        wait_cnt_d[k] = wait_cnt_q[k];
      end
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!reset_n_i) begin
        wait_cnt_q[k] <= 3'd0;
      end else begin
        wait_cnt_q[k] <= wait_cnt_d[k];
      end
    end
  end
`else
  // Pure round-robin winner.
  always_comb begin
    grant_s    = rr_found_s;
    rr_grant_s = rr_found_s;
    win_idx_s  = rr_idx_s;
  end
`endif

  // One-hot grant vector.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_s[ID_W'(k)] = grant_s && (win_idx_s == ID_W'(k));
    end
  end

  // Pipeline next state; everything holds while rsp_stall is high.
  always_comb begin
    ptr_d       = ptr_q;
    s1_v_d      = s1_v_q;
    s1_id_d     = s1_id_q;
    rf_sel_d    = rf_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (!bus.rsp_stall) begin
      s1_v_d = grant_s;
      if (grant_s) begin
        rf_sel_d = bus.req_addr[win_idx_s*ADDR_W +: ADDR_W];
        s1_id_d  = win_idx_s;
      end else begin
        rf_sel_d = rf_sel_q;
      end
      if (rr_grant_s) begin
        ptr_d = next_ptr(win_idx_s);
      end else begin
        ptr_d = ptr_q;
      end
      rsp_valid_d = s1_v_q;
      if (s1_v_q) begin
        rsp_data_d = rf_data_i;
        rsp_id_d   = s1_id_q;
      end else begin
        rsp_data_d = rsp_data_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pipeline state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ptr_q       <= {ID_W{1'b0}};
      s1_v_q      <= 1'b0;
      s1_id_q     <= {ID_W{1'b0}};
      rf_sel_q    <= {ADDR_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_data_q  <= {DATA_W{1'b0}};
    end else begin
      ptr_q       <= ptr_d;
      s1_v_q      <= s1_v_d;
      s1_id_q     <= s1_id_d;
      rf_sel_q    <= rf_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign rf_sel_o      = rf_sel_q;
  assign busy_o        = s1_v_q | rsp_valid_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Testbench for regfile_read_arbiter: table-driven grant vectors plus
// hand-written multi-cycle sequences, responses checked via a scoreboard.
module tb_regfile_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] rf_sel;
  logic [DATA_W-1:0] rf_data;
  logic              busy;

  always #5 clk = ~clk;

  regfile_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_read_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus),
    .rf_sel_o  (rf_sel),
    .rf_data_i (rf_data),
    .busy_o    (busy)
  );

  // Register-file contents model.
  function automatic logic [31:0] rf_model(input logic [4:0] a);
    if (a == 5'd17) return 32'hDEAD_BEEF;
    else return {16'hC0DE, 11'd0, a};
  endfunction

  assign rf_data = rf_model(rf_sel);

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [3:0]  valid;
    logic        stall;
    logic [3:0]  exp_ready;
    logic [19:0] addr;
  } vec_t;

  rsp_t       sb_q[$];
  vec_t       vecs[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] exp_sel  = 5'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    int r = 0;
    for (int k = 0; k < 4; k++) if (oh[k]) r = k;
    return r;
  endfunction

  task automatic add_vec(input logic [3:0] v, input logic s, input logic [3:0] r);
    vec_t t;
    t.valid = v; t.stall = s; t.exp_ready = r; t.addr = 20'($urandom);
    vecs.push_back(t);
  endtask

  // One cycle: drive, check grant and rf_sel, consume/push scoreboard.
  task automatic step(input logic [3:0] v, input logic [19:0] a, input logic s, input logic [3:0] r);
    rsp_t e;
    int   idx;
    @(negedge clk);
    bus.req_valid = v; bus.req_addr = a; bus.rsp_stall = s;
    #1;
    check("req_ready", 64'(bus.req_ready), 64'(r));
    check("rf_sel", 64'(rf_sel), 64'(exp_sel));
    if (bus.rsp_valid && !s) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'(bus.rsp_valid), 64'(1'b0));
      end else begin
        e = sb_q.pop_front();
        check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
      end
    end
    if (r != 4'b0000) begin
      idx = oh2idx(r);
      e.id = 2'(idx);
      e.data = rf_model(a[idx*5 +: 5]);
      sb_q.push_back(e);
      exp_sel = a[idx*5 +: 5];
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req_valid = 4'b1111; bus.req_addr = 20'h0; bus.rsp_stall = 1'b0;

    // Reset held three cycles with all requests asserted.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_ready", 64'(bus.req_ready), 64'(4'b0000));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
      check("rst_rf_sel", 64'(rf_sel), 64'(5'd0));
      check("rst_busy", 64'(busy), 64'(1'b0));
    end
    @(negedge clk);
    reset_n = 1'b1; bus.req_valid = 4'b0000;

    // Single read of R17 by requester 1; exact 2-cycle latency.
    step(4'b0010, {5'd0, 5'd0, 5'd17, 5'd0}, 1'b0, 4'b0010);
    check("single_t0_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    step(4'b0000, 20'h0, 1'b0, 4'b0000);
    check("single_t1_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    check("single_t1_busy", 64'(busy), 64'(1'b1));
    step(4'b0000, 20'h0, 1'b0, 4'b0000);
    check("single_t2_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
    step(4'b0000, 20'h0, 1'b0, 4'b0000);
    check("single_idle_busy", 64'(busy), 64'(1'b0));

    // Stall for 3 cycles with stage 2 and stage 1 both occupied (ptr=2).
    step(4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, 1'b0, 4'b0100);
    step(4'b1000, {5'd20, 5'd0, 5'd0, 5'd0}, 1'b0, 4'b1000);
    for (int c = 0; c < 3; c++) begin
      step(4'b1111, 20'h0, 1'b1, 4'b0000);
      check("stall_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
      check("stall_rsp_id", 64'(bus.rsp_id), 64'(2'd2));
      check("stall_rsp_data", 64'(bus.rsp_data), 64'(rf_model(5'd9)));
    end
    step(4'b0000, 20'h0, 1'b0, 4'b0000);
    check("release_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
    step(4'b0000, 20'h0, 1'b0, 4'b0000);
    check("release_next_valid", 64'(bus.rsp_valid), 64'(1'b1));
    step(4'b0000, 20'h0, 1'b0, 4'b0000);
    check("release_drain_valid", 64'(bus.rsp_valid), 64'(1'b0));
    check("release_drain_busy", 64'(busy), 64'(1'b0));

`ifdef RF_ARB_PRIORITY_EN
    // Requester 0 wins until requester 2 has waited 7 cycles.
    for (int c = 0; c < 7; c++) step(4'b0101, 20'($urandom), 1'b0, 4'b0001);
    step(4'b0101, 20'($urandom), 1'b0, 4'b0100);
    step(4'b0101, 20'($urandom), 1'b0, 4'b0001);
`else
    // Grant table starting from pointer 0.
    add_vec(4'b1000, 1'b0, 4'b1000);
    for (int c = 0; c < 8; c++) add_vec(4'b1111, 1'b0, 4'b0001 << (c % 4));
    add_vec(4'b0100, 1'b0, 4'b0100);
    add_vec(4'b1001, 1'b0, 4'b1000);
    add_vec(4'b1001, 1'b0, 4'b0001);
    add_vec(4'b0100, 1'b0, 4'b0100);
    add_vec(4'b0000, 1'b0, 4'b0000);
    add_vec(4'b0011, 1'b0, 4'b0001);
    vecs[14].addr[4:0] = 5'd0;
    add_vec(4'b0110, 1'b0, 4'b0010);
    add_vec(4'b1111, 1'b1, 4'b0000);
    add_vec(4'b1111, 1'b0, 4'b0100);
    add_vec(4'b0001, 1'b0, 4'b0001);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].valid, vecs[i].addr, vecs[i].stall, vecs[i].exp_ready);
    end
`endif
    for (int c = 0; c < 3; c++) step(4'b0000, 20'h0, 1'b0, 4'b0000);

    // Reset while a transaction sits in stage 1: it must vanish.
    step(4'b0010, {5'd0, 5'd0, 5'd3, 5'd0}, 1'b0, 4'b0010);
    @(negedge clk);
    reset_n = 1'b0; bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    check("midrst_busy", 64'(busy), 64'(1'b0));
    check("midrst_rf_sel", 64'(rf_sel), 64'(5'd0));
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.delete();
    exp_sel = 5'd0;
    for (int c = 0; c < 2; c++) begin
      step(4'b0000, 20'h0, 1'b0, 4'b0000);
      check("postrst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    end

    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
